pipe_stage_buffer: RTL
======================

// Module: pipe_stage_buffer
// PURPOSE
//   Parametrised inter-stage pipeline register for the pipelined core.
//   Carries a control bundle plus NUM_DATA data words from one stage to the next.
//   Adds a 2-entry skid buffer with a valid/ready handshake, so a stall needs no global enable.
//   Also provides synchronous flush with bubble insertion, a sticky halt latch and occupancy.
//   Used between IF/ID, ID/EX, EX/MEM and MEM/WB by changing parameters.
// PARAMETERS
//   DATA_W    16  width of each data word (PC, ALU result, reg operand, ...)
//   NUM_DATA  3   number of data words carried; must be >= 1
//   CTRL_W    10  width of control bundle (opcode, reg ids, mem/wb flags); must be >= 1
//   HLT_BIT   0   index in ctrl of the halt flag; must be < CTRL_W
// PORTS
//   clk        in   1                  rising-edge clock
//   rst        in   1                  synchronous reset, ACTIVE-LOW (sampled on clk rise)
//   flush      in   1                  drop all held and incoming entries this cycle
//   in_valid   in   1                  upstream presents an entry
//   in_ready   out  1                  stage accepts the entry this cycle
//   in_ctrl    in   CTRL_W             control bundle of incoming entry
//   in_data    in   NUM_DATA*DATA_W    data words; word k at [k*DATA_W +: DATA_W]
//   out_valid  out  1                  head entry valid
//   out_ready  in   1                  downstream takes head entry this cycle
//   out_ctrl   out  CTRL_W             head control bundle; forced 0 when out_valid=0
//   out_data   out  NUM_DATA*DATA_W    head data words (registered, no in->out comb path)
//   halted     out  1                  sticky: an entry with ctrl[HLT_BIT]=1 was accepted
//   occupancy  out  2                  entries held: 0, 1 or 2
// BEHAVIOUR
//   accept = in_valid & in_ready; take = out_valid & out_ready.
//   in_ready = (state != FULL) & ~halted & ~flush. No dependence on out_ready.
//   FSM with states EMPTY(occ 0), ONE(main reg full), FULL(main + skid full):
//     EMPTY: accept -> ONE, main <= in.
//     ONE:   accept&take -> ONE, main <= in.
//            accept&~take -> FULL, skid <= in.
//            ~accept&take -> EMPTY.
//            else hold.
//     FULL:  take -> ONE, main <= skid. Otherwise hold (no accept possible).
//   Latency: entry accepted at edge N is visible at out_* after edge N. 1 cycle through EMPTY.
//   Ordering is strictly FIFO. No entry is duplicated or lost except by flush or reset.
//   Priority: reset > flush > normal operation.
//   Flush (sampled at edge): state -> EMPTY, halted -> 0, and the incoming entry is discarded.
//     out_valid=0 and out_ctrl=0 (bubble) after the edge.
//     A take in the flush cycle still counts as delivered downstream.
//   Halt: halted <= 1 on the edge that accepts an entry with in_ctrl[HLT_BIT]=1.
//     That entry is still stored and delivered normally; further accepts are blocked.
//     halted clears only on reset or flush.
//   Held data is unchanged while stalled (out_valid=1, out_ready=0). out_* stable.
//   Data regs need no reset. Valid and ctrl regs must reset.
//   Reset (rst=0 at edge), including mid-operation: state EMPTY, out_valid 0, out_ctrl 0.
//     Also halted 0, occupancy 0, in_ready 1 from the first cycle after reset.
//     Both held entries are discarded.
// TESTING
//   1 Reset: rst=0 two cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occ=0, in_ready=1.
//   2 Streaming: out_ready=1, push ctrl=0x002, data words 1,2,3 then 4,5,6 back-to-back.
//     -> appear 1 cycle later in order; occ stays 1; in_ready stays 1.
//   3 Stall/skid: out_ready=0, push A(data0=0xAAAA) then B(data0=0xBBBB).
//     -> occ=2, in_ready=0; C held off.
//     Raise out_ready -> A, B, C delivered in order, none lost or duplicated.
//   4 Flush in FULL with in_valid=1 and ctrl=0x3FE.
//     -> next cycle out_valid=0, out_ctrl=0, occ=0; that entry never appears.
//   5 Halt: push ctrl=0x001, then push ctrl=0x004.
//     -> halted=1 after the first edge, in_ready=0; 0x001 is delivered, 0x004 is never accepted.
//     Flush -> halted=0.
//   6 Params DATA_W=8, NUM_DATA=1, CTRL_W=4, HLT_BIT=3: repeat 2-3 with data 0xFF -> identical protocol.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush, halt latch.
// Ports: clk, rst(active-low sync), flush, in_*/out_* valid-ready, halted, occupancy.
module pipe_stage_buffer #(
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 3,
  parameter int CTRL_W   = 10,
  parameter int HLT_BIT  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic                       halted,
  output logic [1:0]                 occupancy
);

  localparam int DW = NUM_DATA * DATA_W;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DW-1:0]     main_data, skid_data;
  logic              halted_q;
  logic              accept, take;
  logic              ld_main_in, ld_main_skid, ld_skid;

  assign in_ready  = (state != FULL) & ~halted_q & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign take      = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign halted    = halted_q;
  assign occupancy = state;

  always_comb begin
    state_d      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        unique case (1'b1)
          accept & take: ld_main_in = 1'b1;
          accept & ~take: begin
            state_d = FULL;
            ld_skid = 1'b1;
          end
          ~accept & take: state_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (take) begin
          state_d      = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      halted_q  <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      halted_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept && in_ctrl[HLT_BIT])
        halted_q <= 1'b1;
      if (ld_main_in)
        main_ctrl <= in_ctrl;
      else if (ld_main_skid)
        main_ctrl <= skid_ctrl;
      if (ld_skid)
        skid_ctrl <= in_ctrl;
    end
  end

  // Data path carries no reset; validity comes from state.
  always_ff @(posedge clk) begin
    if (ld_main_in)
      main_data <= in_data;
    else if (ld_main_skid)
      main_data <= skid_data;
    if (ld_skid)
      skid_data <= in_data;
  end

endmodule
